// File: rtl/apb_timeout_guard_pkg.sv
// Shared types for the APB timeout guard.
package apb_timeout_guard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/apb_timeout_guard_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module apb_timeout_guard_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear has priority, increment only below all-ones.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/apb_timeout_guard.sv
// APB pass-through that aborts transfers to a slave that stops answering,
// then holds the stuck slave transfer open and fast-fails new requests.
module apb_timeout_guard
  import apb_timeout_guard_pkg::*;
#(
  parameter  int unsigned AddrWidth     = 32,
  parameter  int unsigned DataWidth     = 32,
  parameter  int unsigned TimeoutCycles = 64,
  parameter  int unsigned StatWidth     = 16,
  localparam int unsigned StrbWidth     = ceil_div(DataWidth, 8)
) (
  input  logic                 pclk_i,
  input  logic                 preset_ni,
  input  logic [AddrWidth-1:0] slv_paddr_i,
  input  logic [2:0]           slv_pprot_i,
  input  logic                 slv_psel_i,
  input  logic                 slv_penable_i,
  input  logic                 slv_pwrite_i,
  input  logic [DataWidth-1:0] slv_pwdata_i,
  input  logic [StrbWidth-1:0] slv_pstrb_i,
  output logic                 slv_pready_o,
  output logic [DataWidth-1:0] slv_prdata_o,
  output logic                 slv_pslverr_o,
  output logic [AddrWidth-1:0] mst_paddr_o,
  output logic [2:0]           mst_pprot_o,
  output logic                 mst_psel_o,
  output logic                 mst_penable_o,
  output logic                 mst_pwrite_o,
  output logic [DataWidth-1:0] mst_pwdata_o,
  output logic [StrbWidth-1:0] mst_pstrb_o,
  input  logic                 mst_pready_i,
  input  logic [DataWidth-1:0] mst_prdata_i,
  input  logic                 mst_pslverr_i,
  output logic                 timeout_o,
  output logic [StatWidth-1:0] timeout_cnt_o
);

  localparam int unsigned      CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] AbortCnt = CntWidth'(TimeoutCycles - 1);

  state_e state_q, state_d;

  logic [AddrWidth-1:0] paddr_q;
  logic [2:0]           pprot_q;
  logic                 pwrite_q;
  logic [DataWidth-1:0] pwdata_q;
  logic [StrbWidth-1:0] pstrb_q;
  logic [StatWidth-1:0] stat_q, stat_d;
  logic [CntWidth-1:0]  acc_cnt;

  logic up_setup, up_access, abort, cnt_clear, cnt_en;

  assign up_setup  = slv_psel_i & ~slv_penable_i;
  assign up_access = slv_psel_i & slv_penable_i;
  // A late slave answer in the last allowed cycle still counts as normal completion.
  assign abort     = (state_q == ACCESS) & up_access & ~mst_pready_i & (acc_cnt == AbortCnt);
  assign cnt_en    = (state_q == ACCESS) & up_access & ~mst_pready_i;
  assign cnt_clear = (state_q != ACCESS) | (state_d != ACCESS);

  apb_timeout_guard_counter #(
    .Width (CntWidth)
  ) i_acc_cnt (
    .clk_i   (pclk_i),
    .rst_ni  (preset_ni),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .count_o (acc_cnt)
  );

  // State register.
  always_ff @(posedge pclk_i) begin
    if (!preset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (up_setup) state_d = ACCESS;
      ACCESS:  if (mst_pready_i) state_d = IDLE;
               else if (abort) state_d = DRAIN;
      DRAIN:   if (mst_pready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture at setup so DRAIN can replay it after upstream moves on.
  always_ff @(posedge pclk_i) begin
    if (!preset_ni) begin
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if ((state_q == IDLE) && up_setup) begin
      paddr_q  <= slv_paddr_i;
      pprot_q  <= slv_pprot_i;
      pwrite_q <= slv_pwrite_i;
      pwdata_q <= slv_pwdata_i;
      pstrb_q  <= slv_pstrb_i;
    end
  end

  // Saturating abort statistic.
  always_comb begin
    stat_d = stat_q;
    if (abort && (stat_q != '1)) begin
      stat_d = stat_q + StatWidth'(1);
    end
  end

  // Statistic register.
  always_ff @(posedge pclk_i) begin
    if (!preset_ni) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign timeout_cnt_o = stat_q;

  // Output logic: pass-through by default, overridden on abort and during DRAIN.
  always_comb begin
    mst_paddr_o   = slv_paddr_i;
    mst_pprot_o   = slv_pprot_i;
    mst_psel_o    = slv_psel_i;
    mst_penable_o = slv_penable_i;
    mst_pwrite_o  = slv_pwrite_i;
    mst_pwdata_o  = slv_pwdata_i;
    mst_pstrb_o   = slv_pstrb_i;
    slv_pready_o  = mst_pready_i;
    slv_prdata_o  = mst_pready_i ? mst_prdata_i : '0;
    slv_pslverr_o = mst_pready_i & mst_pslverr_i;
    timeout_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // An access phase whose setup fell in the final DRAIN cycle never
        // reached the slave; fail it locally instead of forwarding a bare access.
        if (up_access) begin
          mst_psel_o    = 1'b0;
          mst_penable_o = 1'b0;
          slv_pready_o  = 1'b1;
          slv_pslverr_o = 1'b1;
          slv_prdata_o  = '0;
        end
      end
      ACCESS: begin
        if (abort) begin
          slv_pready_o  = 1'b1;
          slv_pslverr_o = 1'b1;
          slv_prdata_o  = '0;
          timeout_o     = 1'b1;
        end
      end
      DRAIN: begin
        mst_paddr_o   = paddr_q;
        mst_pprot_o   = pprot_q;
        mst_psel_o    = 1'b1;
        mst_penable_o = 1'b1;
        mst_pwrite_o  = pwrite_q;
        mst_pwdata_o  = pwdata_q;
        mst_pstrb_o   = pstrb_q;
        slv_pready_o  = up_access;
        slv_pslverr_o = up_access;
        slv_prdata_o  = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_timeout_guard.sv
// Randomized bench for apb_timeout_guard against a transfer-level model.
module tb_apb_timeout_guard;

  localparam int T = 8;

  logic        pclk_i = 1'b0;
  logic        preset_ni;
  logic [31:0] slv_paddr_i;
  logic [2:0]  slv_pprot_i;
  logic        slv_psel_i;
  logic        slv_penable_i;
  logic        slv_pwrite_i;
  logic [31:0] slv_pwdata_i;
  logic [3:0]  slv_pstrb_i;
  logic        slv_pready_o;
  logic [31:0] slv_prdata_o;
  logic        slv_pslverr_o;
  logic [31:0] mst_paddr_o;
  logic [2:0]  mst_pprot_o;
  logic        mst_psel_o;
  logic        mst_penable_o;
  logic        mst_pwrite_o;
  logic [31:0] mst_pwdata_o;
  logic [3:0]  mst_pstrb_o;
  logic        mst_pready_i;
  logic [31:0] mst_prdata_i;
  logic        mst_pslverr_i;
  logic        timeout_o;
  logic [1:0]  timeout_cnt_o;

  apb_timeout_guard #(
    .AddrWidth     (32),
    .DataWidth     (32),
    .TimeoutCycles (T),
    .StatWidth     (2)
  ) dut (
    .pclk_i        (pclk_i),
    .preset_ni     (preset_ni),
    .slv_paddr_i   (slv_paddr_i),
    .slv_pprot_i   (slv_pprot_i),
    .slv_psel_i    (slv_psel_i),
    .slv_penable_i (slv_penable_i),
    .slv_pwrite_i  (slv_pwrite_i),
    .slv_pwdata_i  (slv_pwdata_i),
    .slv_pstrb_i   (slv_pstrb_i),
    .slv_pready_o  (slv_pready_o),
    .slv_prdata_o  (slv_prdata_o),
    .slv_pslverr_o (slv_pslverr_o),
    .mst_paddr_o   (mst_paddr_o),
    .mst_pprot_o   (mst_pprot_o),
    .mst_psel_o    (mst_psel_o),
    .mst_penable_o (mst_penable_o),
    .mst_pwrite_o  (mst_pwrite_o),
    .mst_pwdata_o  (mst_pwdata_o),
    .mst_pstrb_o   (mst_pstrb_o),
    .mst_pready_i  (mst_pready_i),
    .mst_prdata_i  (mst_prdata_i),
    .mst_pslverr_i (mst_pslverr_i),
    .timeout_o     (timeout_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  always #5 pclk_i = ~pclk_i;

  int nvec = 0;
  int nerr = 0;

  // Model: the slave holds a hung transfer (stuck) until rel_cnt reaches 0.
  bit          stuck = 1'b0;
  logic [31:0] stuck_addr = '0;
  int          rel_cnt = -1;
  int          aborts = 0;

  function automatic int exp_stat();
    return (aborts > 3) ? 3 : aborts;
  endfunction

  task automatic drive_hung_slave();
    mst_pready_i  = stuck && (rel_cnt == 0);
    mst_prdata_i  = $urandom;
    mst_pslverr_i = 1'($urandom);
  endtask

  task automatic advance();
    @(posedge pclk_i);
    #1;
    if (stuck) begin
      if (rel_cnt == 0) stuck = 1'b0;
      else if (rel_cnt > 0) rel_cnt--;
    end
  endtask

  // resp: access cycle in which the slave answers (beyond T means never).
  // hang: DRAIN cycles before the hung slave finally answers (-1 = until told).
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input int resp, input logic [31:0] rd, input bit rerr, input int hang);
    bit fwd;
    bit done;
    bit exp_rdy, exp_err, exp_to;
    logic [31:0] exp_rd;
    fwd = !stuck;
    slv_psel_i = 1'b1; slv_penable_i = 1'b0; slv_paddr_i = addr; slv_pwrite_i = wr;
    slv_pwdata_i = wd; slv_pstrb_i = 4'($urandom); slv_pprot_i = 3'($urandom);
    if (fwd) begin
      mst_pready_i = 1'b0; mst_prdata_i = $urandom; mst_pslverr_i = 1'($urandom);
    end else begin
      drive_hung_slave();
    end
    @(negedge pclk_i);
    nvec++;
    if (slv_pready_o !== 1'b0) begin
      nerr++; $display("FAIL setup_pready addr=%h got=%b exp=0", addr, slv_pready_o);
    end
    nvec++;
    if (timeout_cnt_o !== 2'(exp_stat())) begin
      nerr++; $display("FAIL setup_stat got=%0d exp=%0d", timeout_cnt_o, exp_stat());
    end
    nvec++;
    if (fwd && (mst_psel_o !== 1'b1 || mst_penable_o !== 1'b0 || mst_paddr_o !== addr ||
                mst_pwdata_o !== wd || mst_pwrite_o !== wr || mst_pstrb_o !== slv_pstrb_i)) begin
      nerr++; $display("FAIL setup_fwd got sel=%b en=%b addr=%h wd=%h exp sel=1 en=0 addr=%h wd=%h",
                       mst_psel_o, mst_penable_o, mst_paddr_o, mst_pwdata_o, addr, wd);
    end else if (!fwd && (mst_psel_o !== 1'b1 || mst_penable_o !== 1'b1 || mst_paddr_o !== stuck_addr)) begin
      nerr++; $display("FAIL setup_drain got sel=%b en=%b addr=%h exp sel=1 en=1 addr=%h",
                       mst_psel_o, mst_penable_o, mst_paddr_o, stuck_addr);
    end
    advance();
    slv_penable_i = 1'b1;
    if (!fwd) begin
      drive_hung_slave();
      @(negedge pclk_i);
      nvec++;
      if (slv_pready_o !== 1'b1 || slv_pslverr_o !== 1'b1 || slv_prdata_o !== 32'h0 || timeout_o !== 1'b0) begin
        nerr++; $display("FAIL fastfail addr=%h got rdy=%b err=%b rd=%h to=%b exp rdy=1 err=1 rd=0 to=0",
                         addr, slv_pready_o, slv_pslverr_o, slv_prdata_o, timeout_o);
      end
      nvec++;
      if (mst_psel_o !== stuck || (stuck && mst_paddr_o !== stuck_addr)) begin
        nerr++; $display("FAIL fastfail_mst got sel=%b addr=%h exp sel=%b addr=%h",
                         mst_psel_o, mst_paddr_o, stuck, stuck_addr);
      end
      advance();
    end else begin
      done = 1'b0;
      for (int k = 1; k <= T && !done; k++) begin
        mst_pready_i  = (k == resp);
        mst_prdata_i  = (k == resp) ? rd : $urandom;
        mst_pslverr_i = (k == resp) ? rerr : 1'($urandom);
        exp_rdy = (k == resp) || (k == T);
        exp_err = (k == resp) ? rerr : (k == T);
        exp_rd  = (k == resp) ? rd : 32'h0;
        exp_to  = (k == T) && (k != resp);
        @(negedge pclk_i);
        nvec++;
        if (slv_pready_o !== exp_rdy || slv_pslverr_o !== exp_err || slv_prdata_o !== exp_rd ||
            timeout_o !== exp_to) begin
          nerr++; $display("FAIL access addr=%h cyc=%0d got rdy=%b err=%b rd=%h to=%b exp rdy=%b err=%b rd=%h to=%b",
                           addr, k, slv_pready_o, slv_pslverr_o, slv_prdata_o, timeout_o,
                           exp_rdy, exp_err, exp_rd, exp_to);
        end
        nvec++;
        if (mst_psel_o !== 1'b1 || mst_penable_o !== 1'b1 || mst_paddr_o !== addr || mst_pwrite_o !== wr) begin
          nerr++; $display("FAIL access_mst cyc=%0d got sel=%b en=%b addr=%h exp sel=1 en=1 addr=%h",
                           k, mst_psel_o, mst_penable_o, mst_paddr_o, addr);
        end
        advance();
        if (exp_rdy) done = 1'b1;
        if (exp_to) begin
          stuck = 1'b1; stuck_addr = addr; rel_cnt = hang; aborts++;
        end
      end
    end
    slv_psel_i = 1'b0; slv_penable_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      slv_psel_i = 1'b0; slv_penable_i = 1'b0;
      drive_hung_slave();
      @(negedge pclk_i);
      nvec++;
      if (slv_pready_o !== 1'b0 || slv_pslverr_o !== 1'b0 || slv_prdata_o !== 32'h0 || timeout_o !== 1'b0) begin
        nerr++; $display("FAIL idle_resp got rdy=%b err=%b rd=%h to=%b exp all 0",
                         slv_pready_o, slv_pslverr_o, slv_prdata_o, timeout_o);
      end
      nvec++;
      if (mst_psel_o !== stuck || (stuck && (mst_penable_o !== 1'b1 || mst_paddr_o !== stuck_addr))) begin
        nerr++; $display("FAIL idle_mst got sel=%b en=%b addr=%h exp sel=%b addr=%h",
                         mst_psel_o, mst_penable_o, mst_paddr_o, stuck, stuck_addr);
      end
      nvec++;
      if (timeout_cnt_o !== 2'(exp_stat())) begin
        nerr++; $display("FAIL idle_stat got=%0d exp=%0d", timeout_cnt_o, exp_stat());
      end
      advance();
    end
  endtask

  task automatic apply_reset(input int cycles);
    preset_ni = 1'b0;
    slv_psel_i = 1'b0; slv_penable_i = 1'b0; mst_pready_i = 1'b0;
    repeat (cycles) @(posedge pclk_i);
    #1;
    preset_ni = 1'b1;
    stuck = 1'b0; rel_cnt = -1; aborts = 0;
  endtask

  task automatic test_reset();
    slv_paddr_i = '0; slv_pprot_i = '0; slv_pwrite_i = 1'b0; slv_pwdata_i = '0; slv_pstrb_i = '0;
    mst_prdata_i = '0; mst_pslverr_i = 1'b0;
    apply_reset(3);
    @(negedge pclk_i);
    nvec++;
    if (mst_psel_o !== 1'b0 || timeout_o !== 1'b0 || timeout_cnt_o !== 2'd0 || slv_pready_o !== 1'b0) begin
      nerr++; $display("FAIL reset got sel=%b to=%b cnt=%0d rdy=%b exp all 0",
                       mst_psel_o, timeout_o, timeout_cnt_o, slv_pready_o);
    end
    advance();
  endtask

  task automatic test_write_wait3();
    xfer(1'b1, 32'h100, 32'hDEADBEEF, 4, 32'h0, 1'b0, 0);
    idle(1);
  endtask

  task automatic test_read_timeout();
    xfer(1'b0, 32'h40, 32'h0, 0, 32'h0, 1'b0, -1);
    idle(3);
  endtask

  task automatic test_drain_fastfail();
    xfer(1'b0, 32'h80, 32'h0, 1, 32'hAAAA5555, 1'b0, 0);
    rel_cnt = 0;
    idle(1);
    xfer(1'b0, 32'h80, 32'h0, 2, 32'h5555AAAA, 1'b0, 0);
    idle(1);
  endtask

  task automatic test_ready_at_last();
    xfer(1'b0, 32'h200, 32'h0, T, 32'h1234, 1'b0, 0);
    idle(1);
  endtask

  task automatic test_reset_in_drain();
    xfer(1'b1, 32'h300, 32'h77, 0, 32'h0, 1'b0, -1);
    idle(2);
    apply_reset(1);
    @(negedge pclk_i);
    nvec++;
    if (mst_psel_o !== 1'b0 || timeout_cnt_o !== 2'd0) begin
      nerr++; $display("FAIL reset_drain got sel=%b cnt=%0d exp sel=0 cnt=0", mst_psel_o, timeout_cnt_o);
    end
    advance();
  endtask

  task automatic test_stat_saturation();
    int exp_tab [5] = '{1, 2, 3, 3, 3};
    apply_reset(1);
    for (int i = 0; i < 5; i++) begin
      xfer(1'b0, 32'h400 + 32'(i * 4), 32'h0, 0, 32'h0, 1'b0, 0);
      idle(1);
      nvec++;
      if (timeout_cnt_o !== 2'(exp_tab[i])) begin
        nerr++; $display("FAIL stat_sat idx=%0d got=%0d exp=%0d", i, timeout_cnt_o, exp_tab[i]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset(1);
    for (int i = 0; i < 60; i++) begin
      xfer(1'($urandom), $urandom & 32'hFFFC, $urandom, $urandom_range(1, T + 2),
           $urandom, 1'($urandom), $urandom_range(0, 5));
      idle($urandom_range(0, 2));
    end
    while (stuck && rel_cnt >= 0) idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_wait3();
    test_read_timeout();
    test_drain_fastfail();
    test_ready_at_last();
    test_reset_in_drain();
    test_stat_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
